// File: rtl/burst_sram_ctrl_if.sv
// Request, write-beat and read-beat bundle between a bus master and burst_sram_ctrl.
// rd_perr exists only when BSRAM_PARITY_EN is defined.
interface burst_sram_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_last;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
`ifdef BSRAM_PARITY_EN
    logic              rd_perr;
`endif

    modport master (
`ifdef BSRAM_PARITY_EN
        input  rd_perr,
`endif
        output req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
        input  req_ready, wr_ready, rd_valid, rd_last, rd_data, busy, done
    );

    modport slave (
`ifdef BSRAM_PARITY_EN
        output rd_perr,
`endif
        input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
        output req_ready, wr_ready, rd_valid, rd_last, rd_data, busy, done
    );
endinterface

// File: rtl/burst_sram_ctrl.sv
// Single-port burst SRAM: one beat per clock from a start address, wrapping modulo DEPTH.
// Define BSRAM_PARITY_EN to store an even-parity bit per word and flag mismatches on rd_perr.
module burst_sram_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
) (
    input logic               clk,
    input logic               rst,
    burst_sram_ctrl_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
`ifdef BSRAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              accept, wr_beat, rd_beat, last_beat;
    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  wr_word, rd_word;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        wr_beat    = 1'b0;
        rd_beat    = 1'b0;
        last_beat  = (remaining == LEN_W'(1));
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (bus.req_len != '0) next_state = bus.req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                if (bus.wr_valid) begin
                    wr_beat = 1'b1;
                    if (last_beat) next_state = IDLE;
                end
            end
            READ: begin
                rd_beat = 1'b1;
                if (last_beat) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.wr_ready  = (state == WRITE);
    assign bus.busy      = (state != IDLE);

`ifdef BSRAM_PARITY_EN
    assign wr_word = {^bus.wr_data, bus.wr_data};
`else
    assign wr_word = bus.wr_data;
`endif
    assign rd_word = mem[cur_addr];

    // A write on the reset edge is suppressed so an abandoned burst leaves no partial beat.
    always_ff @(posedge clk) begin
        if (wr_beat && !rst) mem[cur_addr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr     <= '0;
            remaining    <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_last  <= 1'b0;
            bus.rd_data  <= '0;
            bus.done     <= 1'b0;
`ifdef BSRAM_PARITY_EN
            bus.rd_perr  <= 1'b0;
`endif
        end else begin
            bus.rd_valid <= rd_beat;
            bus.rd_last  <= rd_beat && last_beat;
            bus.done     <= (accept && (bus.req_len == '0)) || ((wr_beat || rd_beat) && last_beat);
            if (rd_beat) bus.rd_data <= rd_word[DATA_W-1:0];
`ifdef BSRAM_PARITY_EN
            // XOR over data plus stored bit is 1 exactly when even parity is violated.
            bus.rd_perr  <= rd_beat && (^rd_word);
`endif
            if (accept) begin
                cur_addr  <= bus.req_addr;
                remaining <= bus.req_len;
            end else if (wr_beat || rd_beat) begin
                cur_addr  <= cur_addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
        end
    end
endmodule
